// File: rtl/tone_i2s_tx_pkg.sv
// Shared constants, the waveform-select encoding and the phase-to-waveform
// shaper used by the tone generator and its I2S serialiser.
package tone_i2s_tx_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SAMPLE_W   = 16;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    WAVE_SQR = 2'd0,
    WAVE_SAW = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_OFF = 2'd3
  } wave_e;

  // Turns a 16-bit phase into a signed 16-bit waveform value.
  // The sawtooth is the phase re-centred around zero; the triangle folds the
  // doubled phase back down in the upper half of the cycle and re-centres it.
  function automatic logic [SAMPLE_W-1:0] shape_wave(
    input wave_e               sel,
    input logic [SAMPLE_W-1:0] ph,
    input logic [SAMPLE_W-1:0] amp
  );
    logic [SAMPLE_W-1:0] tri_t;
    logic [SAMPLE_W-1:0] res;
    tri_t = ph[15] ? ~{ph[14:0], 1'b0} : {ph[14:0], 1'b0};
    case (sel)
      WAVE_SQR: res = ph[15] ? (~amp + 16'd1) : amp;
      WAVE_SAW: res = {~ph[15], ph[14:0]};
      WAVE_TRI: res = {~tri_t[15], tri_t[14:0]};
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tone_i2s_tx_if.sv
// Control inputs from the player plus the codec-facing I2S pins and the
// frame strobe. The player side drives the master modport, the tone
// transmitter sits on the slave modport.
interface tone_i2s_tx_if;

  logic [15:0] freq_word;
  logic        freq_valid;
  logic        mute;
  logic [1:0]  wave_sel;
  logic [2:0]  volume;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        frame_tick;

  modport master (
    output freq_word, freq_valid, mute, wave_sel, volume,
    input  aud_bclk, aud_daclrck, aud_dacdat, frame_tick
  );

  modport slave (
    input  freq_word, freq_valid, mute, wave_sel, volume,
    output aud_bclk, aud_daclrck, aud_dacdat, frame_tick
  );

endinterface

// File: rtl/tone_i2s_tx_i2s_master_tx.sv
// I2S master serialiser: divides the system clock down to BCLK, counts the
// 64 bit slots of a frame and shifts the 16-bit sample out MSB first in both
// channel slots with the one-bit I2S delay. All slot/data changes happen on
// BCLK falling edges; the strobe marks the wrap from slot 63 to slot 0.
module tone_i2s_tx_i2s_master_tx
  import tone_i2s_tx_pkg::*;
#(
  parameter int BCLK_HALF = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                boundary_o,
  output logic                bclk_o,
  output logic                lrck_o,
  output logic                dacdat_o
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 bclk_q, bclk_d;
  logic [BIT_CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic                 divTerm;
  logic                 fallEvent;
  logic [4:0]           slotPos;
  logic [3:0]           bitIdx;

  // Divider, BCLK toggle and slot counter next-state; the counter only moves on falling edges.
  always_comb begin
    divTerm    = (div_q == DIV_TERM);
    fallEvent  = divTerm && bclk_q;
    div_d      = divTerm ? '0 : div_q + DIV_W'(1);
    bclk_d     = divTerm ? ~bclk_q : bclk_q;
    bitCnt_d   = fallEvent ? bitCnt_q + BIT_CNT_W'(1) : bitCnt_q;
    boundary_o = fallEvent && (bitCnt_q == LAST_BIT);
  end

  // Timing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      bitCnt_q <= '0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      bitCnt_q <= bitCnt_d;
    end
  end

  // Slot 0 is the I2S delay bit, slots 1..16 carry the sample MSB first, the rest pad with zero.
  always_comb begin
    slotPos  = bitCnt_q[4:0];
    bitIdx   = 4'(5'd16 - slotPos);
    lrck_o   = bitCnt_q[5];
    bclk_o   = bclk_q;
    dacdat_o = 1'b0;
    if ((slotPos != 5'd0) && (slotPos <= 5'd16)) begin
      dacdat_o = sample_i[bitIdx];
    end
  end

endmodule

// File: rtl/tone_i2s_tx.sv
// Tone generator feeding the board codec: latches the player's phase
// increment, advances a 16-bit phase once per audio frame, shapes it into a
// square/saw/triangle sample, applies the volume shift and hands the sample
// to the I2S serialiser which repeats it in the left and right slots.
module tone_i2s_tx
  import tone_i2s_tx_pkg::*;
#(
  parameter int                  BCLK_HALF = 8,
  parameter logic [SAMPLE_W-1:0] AMP       = 16'h3FFF
) (
  input  logic          clk,
  input  logic          rst_n,
  tone_i2s_tx_if.slave  bus
);

  logic [SAMPLE_W-1:0]        pendingFreq_q, pendingFreq_d;
  logic [SAMPLE_W-1:0]        activeFreq_q, activeFreq_d;
  logic [SAMPLE_W-1:0]        phase_q, phase_d;
  logic [SAMPLE_W-1:0]        sample_q, sample_d;
  logic [SAMPLE_W-1:0]        effFreq;
  logic [SAMPLE_W-1:0]        nextPhase;
  logic [SAMPLE_W-1:0]        shaped;
  logic signed [SAMPLE_W-1:0] scaled;
  logic                       silent;
  logic                       boundary;
  logic                       bclk;
  logic                       lrck;
  logic                       dacdat;

  tone_i2s_tx_i2s_master_tx #(
    .BCLK_HALF (BCLK_HALF)
  ) u_i2s (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_i   (sample_q),
    .boundary_o (boundary),
    .bclk_o     (bclk),
    .lrck_o     (lrck),
    .dacdat_o   (dacdat)
  );

  assign bus.aud_bclk    = bclk;
  assign bus.aud_daclrck = lrck;
  assign bus.aud_dacdat  = dacdat;
  assign bus.frame_tick  = boundary;

  // A write in the boundary cycle wins, so the freshly written increment is the one applied there.
  // Mute, waveform and volume only matter at the boundary, so a frame in flight is never cut.
  always_comb begin
    effFreq       = bus.freq_valid ? bus.freq_word : pendingFreq_q;
    pendingFreq_d = effFreq;
    activeFreq_d  = activeFreq_q;
    phase_d       = phase_q;
    sample_d      = sample_q;
    nextPhase     = phase_q + effFreq;
    silent        = (wave_e'(bus.wave_sel) == WAVE_OFF) || (effFreq == '0);
    shaped        = shape_wave(wave_e'(bus.wave_sel), nextPhase, AMP);
    scaled        = $signed(shaped) >>> bus.volume;
    if (boundary) begin
      activeFreq_d = effFreq;
      if (bus.mute) begin
        phase_d  = '0;
        sample_d = '0;
      end else if (silent) begin
        sample_d = '0;
      end else begin
        phase_d  = nextPhase;
        sample_d = scaled;
      end
    end
  end

  // Increment, phase accumulator and sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendingFreq_q <= '0;
      activeFreq_q  <= '0;
      phase_q       <= '0;
      sample_q      <= '0;
    end else begin
      pendingFreq_q <= pendingFreq_d;
      activeFreq_q  <= activeFreq_d;
      phase_q       <= phase_d;
      sample_q      <= sample_d;
    end
  end

endmodule

// File: tb/tb_tone_i2s_tx.sv
// Bench for the tone I2S transmitter: decodes each frame off the I2S pins
// like a codec would (sampling DACDAT on BCLK rising edges) and compares the
// recovered left/right words against an arithmetic model of the tone path.
module tb_tone_i2s_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: pending increment, phase and expected sample.
  int          mPending;
  int          mPhase;
  logic [15:0] mSample;

  tone_i2s_tx_if bus ();

  tone_i2s_tx #(
    .BCLK_HALF (8),
    .AMP       (16'h3FFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Waveform value from phase using plain arithmetic, then the volume shift.
  function automatic logic [15:0] ref_sample(input int ph, input int wave, input int vol);
    int s;
    int t;
    case (wave)
      0: s = (ph >= 32768) ? -16383 : 16383;
      1: s = ph - 32768;
      2: begin
        t = (ph < 32768) ? 2 * ph : 65535 - 2 * (ph - 32768);
        s = t - 32768;
      end
      default: s = 0;
    endcase
    s = s >>> vol;
    return s[15:0];
  endfunction

  // Model of what happens at a frame boundary with the inputs as currently driven.
  task automatic do_boundary();
    if (bus.mute) begin
      mPhase  = 0;
      mSample = 16'h0000;
    end else if (bus.wave_sel == 2'd3 || mPending == 0) begin
      mSample = 16'h0000;
    end else begin
      mPhase  = (mPhase + mPending) % 65536;
      mSample = ref_sample(mPhase, int'(bus.wave_sel), int'(bus.volume));
    end
  endtask

  // One-clock write of a new increment into the pending register.
  task automatic pulse_freq(input logic [15:0] w);
    bus.freq_word  = w;
    bus.freq_valid = 1'b1;
    mPending       = int'(w);
    @(negedge clk);
    bus.freq_valid = 1'b0;
  endtask

  // Waits for the frame strobe with a cycle bound; cyc is negedges waited.
  task automatic wait_tick(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 1100) begin
      @(negedge clk);
      cyc++;
      if (bus.frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Decodes one 64-slot frame starting right after a strobe.
  task automatic capture_frame(output logic [15:0] leftW, output logic [15:0] rightW,
                               output int padOnes, output int lrckBad, output bit ok);
    int   k;
    int   guard;
    logic prevB;
    k = 0;
    guard = 0;
    leftW = '0;
    rightW = '0;
    padOnes = 0;
    lrckBad = 0;
    prevB = bus.aud_bclk;
    while (k < 64 && guard < 1100) begin
      @(negedge clk);
      guard++;
      if (!prevB && bus.aud_bclk) begin
        if (k >= 1 && k <= 16) leftW[16-k] = bus.aud_dacdat;
        else if (k >= 33 && k <= 48) rightW[48-k] = bus.aud_dacdat;
        else if (bus.aud_dacdat !== 1'b0) padOnes++;
        if (bus.aud_daclrck !== (k >= 32)) lrckBad++;
        k++;
      end
      prevB = bus.aud_bclk;
    end
    ok = (k == 64);
  endtask

  // Next strobe, model update, then decode the frame that follows.
  task automatic step_frame(output logic [15:0] l, output logic [15:0] r,
                            output int pad, output int lb, output bit ok);
    bit tOk;
    bit cOk;
    int cyc;
    wait_tick(tOk, cyc);
    if (tOk) do_boundary();
    capture_frame(l, r, pad, lb, cOk);
    ok = tOk && cOk;
  endtask

  task automatic test_reset();
    bit   ok;
    int   cyc;
    int   n;
    bit   found;
    rst_n          = 1'b0;
    bus.freq_word  = '0;
    bus.freq_valid = 1'b0;
    bus.mute       = 1'b0;
    bus.wave_sel   = 2'd0;
    bus.volume     = 3'd0;
    mPending = 0;
    mPhase   = 0;
    mSample  = 16'h0000;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.aud_bclk, bus.aud_daclrck, bus.aud_dacdat, bus.frame_tick} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000",
               {bus.aud_bclk, bus.aud_daclrck, bus.aud_dacdat, bus.frame_tick});
    end
    rst_n = 1'b1;
    wait_tick(ok, cyc);
    if (ok) do_boundary();
    checks++;
    if (!ok || cyc < 1023 || cyc > 1025) begin
      errors++;
      $display("[TB] FAIL first_tick: got %0d cycles (seen=%0d) expected 1024+/-1", cyc, ok);
    end
    // BCLK period measured between consecutive rising edges.
    n = 0;
    while (bus.aud_bclk !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    while (bus.aud_bclk !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    @(negedge clk);
    n++;
    while (bus.aud_bclk !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    while (bus.aud_bclk !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != 16) begin
      errors++;
      $display("[TB] FAIL bclk_period: got %0d clk expected 16", n);
    end
    wait_tick(ok, cyc);
    if (ok) do_boundary();
    wait_tick(ok, cyc);
    if (ok) do_boundary();
    checks++;
    if (!ok || cyc != 1024) begin
      errors++;
      $display("[TB] FAIL tick_period: got %0d cycles (seen=%0d) expected 1024", cyc, ok);
    end
    // Reset in the right-channel half while BCLK is high.
    found = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (bus.aud_daclrck === 1'b1 && bus.aud_bclk === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!found || {bus.aud_bclk, bus.aud_daclrck, bus.aud_dacdat, bus.frame_tick} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b (armed=%0d) expected 0000",
               {bus.aud_bclk, bus.aud_daclrck, bus.aud_dacdat, bus.frame_tick}, found);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mPending = 0;
    mPhase   = 0;
    mSample  = 16'h0000;
    wait_tick(ok, cyc);
    if (ok) do_boundary();
    checks++;
    if (!ok || cyc < 1023 || cyc > 1025) begin
      errors++;
      $display("[TB] FAIL tick_after_rerelease: got %0d cycles (seen=%0d) expected 1024+/-1", cyc, ok);
    end
  endtask

  task automatic test_square();
    logic [15:0] l, r;
    int          pad, lb;
    bit          ok;
    logic [34:0] got, exp;
    repeat (100) @(negedge clk);
    bus.wave_sel = 2'd0;
    bus.volume   = 3'd0;
    pulse_freq(16'd1365);
    for (int f = 1; f <= 25; f++) begin
      step_frame(l, r, pad, lb, ok);
      got = {ok, pad == 0, lb == 0, l, r};
      exp = {3'b111, mSample, mSample};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL square_f%0d: got %h expected %h", f, got, exp);
      end
      if (f == 1 || f == 24 || f == 25) begin
        checks++;
        if (l !== ((f == 25) ? 16'hC001 : 16'h3FFF)) begin
          errors++;
          $display("[TB] FAIL square_sign_f%0d: got %h expected %h", f, l,
                   (f == 25) ? 16'hC001 : 16'h3FFF);
        end
      end
    end
  endtask

  task automatic test_saw_tri();
    logic [15:0] l, r;
    int          pad, lb;
    bit          ok;
    logic [34:0] got, exp;
    logic [15:0] sawTab [4];
    logic [15:0] triTab [4];
    sawTab = '{16'hC000, 16'h0000, 16'h4000, 16'h8000};
    triTab = '{16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
    bus.mute     = 1'b1;
    bus.wave_sel = 2'd1;
    pulse_freq(16'h4000);
    step_frame(l, r, pad, lb, ok);
    checks++;
    if ({ok, l, r} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL saw_clear: got %h expected %h", {ok, l, r}, {1'b1, 32'h0});
    end
    bus.mute = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) bus.wave_sel = 2'd2;
      step_frame(l, r, pad, lb, ok);
      got = {ok, pad == 0, lb == 0, l, r};
      exp = {3'b111, (i < 4) ? sawTab[i] : triTab[i-4], mSample};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL %s_%0d: got %h expected %h", (i < 4) ? "saw" : "tri", i % 4, got, exp);
      end
    end
  endtask

  task automatic test_volume();
    logic [15:0] l, r;
    int          pad, lb;
    bit          ok;
    logic [34:0] got, exp;
    bus.wave_sel = 2'd0;
    bus.volume   = 3'd2;
    for (int i = 0; i < 4; i++) begin
      step_frame(l, r, pad, lb, ok);
      got = {ok, pad == 0, lb == 0, l, r};
      exp = {3'b111, mSample, mSample};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL volume_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_mute_update();
    logic [15:0] l, r, held;
    int          pad, lb, cyc;
    bit          ok, tOk;
    logic [34:0] got, exp;
    bus.volume = 3'd0;
    step_frame(l, r, pad, lb, ok);
    held = mSample;
    // Mute raised in the middle of a frame must leave that frame intact.
    wait_tick(tOk, cyc);
    if (tOk) do_boundary();
    fork
      capture_frame(l, r, pad, lb, ok);
      begin
        repeat (400) @(negedge clk);
        bus.mute = 1'b1;
      end
    join
    got = {tOk && ok, pad == 0, lb == 0, l, r};
    exp = {3'b111, mSample, mSample};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL mute_inflight: got %h expected %h", got, exp);
    end
    step_frame(l, r, pad, lb, ok);
    got = {ok, pad == 0, lb == 0, l, r};
    exp = {3'b111, 32'h0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL mute_zero: got %h expected %h", got, exp);
    end
    bus.mute = 1'b0;
    step_frame(l, r, pad, lb, ok);
    got = {ok, pad == 0, lb == 0, l, r};
    exp = {3'b111, mSample, mSample};
    checks++;
    if (got !== exp || mPhase != 16'h4000) begin
      errors++;
      $display("[TB] FAIL mute_restart: got %h expected %h", got, exp);
    end
    // New increment written around slot 20: current frame keeps the old sample.
    wait_tick(tOk, cyc);
    if (tOk) do_boundary();
    held = mSample;
    fork
      capture_frame(l, r, pad, lb, ok);
      begin
        repeat (324) @(negedge clk);
        pulse_freq(16'h2000);
      end
    join
    got = {tOk && ok, pad == 0, lb == 0, l, r};
    exp = {3'b111, held, held};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL update_midframe: got %h expected %h", got, exp);
    end
    step_frame(l, r, pad, lb, ok);
    got = {ok, pad == 0, lb == 0, l, r};
    exp = {3'b111, mSample, mSample};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL update_applied: got %h expected %h", got, exp);
    end
    // Write landing in the boundary cycle itself is used at that boundary.
    bus.wave_sel = 2'd1;
    wait_tick(tOk, cyc);
    bus.freq_word  = 16'h6000;
    bus.freq_valid = 1'b1;
    mPending       = 16'h6000;
    if (tOk) do_boundary();
    @(negedge clk);
    bus.freq_valid = 1'b0;
    capture_frame(l, r, pad, lb, ok);
    got = {tOk && ok, pad == 0, lb == 0, l, r};
    exp = {3'b111, mSample, mSample};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL update_coincident: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_silence();
    logic [15:0] l, r;
    int          pad, lb;
    bit          ok;
    logic [34:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) bus.wave_sel = 2'd3;
      if (i == 2) begin
        bus.wave_sel = 2'd0;
        pulse_freq(16'h0000);
      end
      if (i == 4) pulse_freq(16'd1000);
      step_frame(l, r, pad, lb, ok);
      got = {ok, pad == 0, lb == 0, l, r};
      exp = {3'b111, mSample, mSample};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL silence_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] l, r;
    int          pad, lb;
    bit          ok;
    logic [34:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      bus.wave_sel = 2'($urandom_range(0, 3));
      bus.volume   = 3'($urandom_range(0, 7));
      bus.mute     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) pulse_freq(16'($urandom_range(1, 65535)));
      step_frame(l, r, pad, lb, ok);
      got = {ok, pad == 0, lb == 0, l, r};
      exp = {3'b111, mSample, mSample};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_square();
    test_saw_tri();
    test_volume();
    test_mute_update();
    test_silence();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
